timer_control: RTL

TIMER_CONTROL -- requirements
Module: timer_control

---
 rtl/timer_control.sv | 118 +++++++++++
 1 files changed

// File: rtl/timer_control.sv
// Stopwatch control: debounced start/stop and clear buttons, 1 Hz enable pulse.
// Optional macro CLEAR_IN_RUN_EN lets a clear press also stop a running timer.
module timer_control #(
  parameter int TICK_DIV  = 50000000,
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start,
  input  logic btn_clear,
  output logic start_stop,
  output logic clr_n,
  output logic running
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DB_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic          r_start_stop;
  logic          r_clr_n;
  logic [1:0]    w_raw;
  logic [1:0]    w_press;
  logic          w_start;
  logic          w_clear;
  logic          w_clr_ok;
  logic          w_toggle;

  assign w_raw = {btn_clear, btn_start};

  // Index 0 is start, index 1 is clear.
  for (genvar g = 0; g < 2; g++) begin : g_db
    logic [1:0]    r_sync;
    logic          r_lvl;
    logic          r_press;
    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sync  <= '0;
        r_lvl   <= 1'b0;
        r_press <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync  <= {r_sync[0], w_raw[g]};
        r_press <= 1'b0;
        if (r_sync[1] == r_lvl) begin
          r_cnt <= '0;
        end else if (r_cnt == DB_LAST) begin
          r_cnt   <= '0;
          r_lvl   <= r_sync[1];
          r_press <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end
    end

    assign w_press[g] = r_press;
  end

  assign w_start  = w_press[0];
  assign w_clear  = w_press[1];
  // A coincident clear press always swallows the start press.
  assign w_toggle = w_start & ~w_clear;

`ifdef CLEAR_IN_RUN_EN
  assign w_clr_ok = w_clear;
`else
  assign w_clr_ok = w_clear & (r_state == S_IDLE);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pre        <= '0;
      r_start_stop <= 1'b0;
      r_clr_n      <= 1'b0;
    end else begin
      r_clr_n      <= ~w_clr_ok;
      r_start_stop <= 1'b0;
      if (w_clr_ok) begin
        r_state <= S_IDLE;
        r_pre   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_toggle) r_state <= S_RUN;
          end
          S_RUN: begin
            if (w_toggle) begin
              r_state <= S_IDLE;
            end else if (r_pre == PRE_LAST) begin
              r_pre        <= '0;
              r_start_stop <= 1'b1;
            end else begin
              r_pre <= r_pre + PW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign start_stop = r_start_stop;
  assign clr_n      = r_clr_n;
  assign running    = (r_state == S_RUN);

endmodule
